// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial wide adder.
//   state_t  : controller states (idle / running nibbles / result held)
//   NIBBLE_W : width of one adder slice
package nibble_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for nibble_serial_adder.
//   in_valid/in_ready   : operand handshake (a, b, cin)
//   out_valid/out_ready : result handshake (sum, cout)
// The slave modport is the adder; the master modport is its user.
interface nibble_serial_adder_if
    import nibble_adder_pkg::*;
#(
    parameter int NIBBLES = 4
) ();

    localparam int WIDTH = NIBBLE_W * NIBBLES;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );

endinterface

// File: rtl/nibble_serial_adder_fourbit.sv
// fourBitAdder: 4-bit ripple-carry adder slice.
//   a_i, b_i : 4-bit addends
//   cin_i    : carry in
//   sum_o    : 4-bit sum
//   cout_o   : carry out of bit 3
module fourBitAdder
    import nibble_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a_i,
    input  logic [NIBBLE_W-1:0] b_i,
    input  logic                cin_i,
    output logic [NIBBLE_W-1:0] sum_o,
    output logic                cout_o
);

    logic carry_s;

    // Ripple the carry bit by bit through the slice.
    always_comb begin
        carry_s = cin_i;
        sum_o   = {NIBBLE_W{1'b0}};
        for (int i = 0; i < NIBBLE_W; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ carry_s;
            carry_s  = (a_i[i] & b_i[i]) | (carry_s & (a_i[i] ^ b_i[i]));
        end
        cout_o = carry_s;
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit adder (WIDTH = 4*NIBBLES) built from one
// 4-bit ripple slice used once per cycle, least significant nibble first.
// The slice carry-out is registered and fed into the next nibble.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of nibble_serial_adder_if (operand in, result out)
module nibble_serial_adder
    import nibble_adder_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    nibble_serial_adder_if.slave  bus
);

    localparam int WIDTH = NIBBLE_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    logic [NIBBLE_W-1:0] add_a_s;
    logic [NIBBLE_W-1:0] add_b_s;
    logic [NIBBLE_W-1:0] add_sum_s;
    logic                add_cout_s;

    // Pick nibble 'sel' out of a word. Values of sel beyond the last nibble
    // (reachable only outside S_RUN) yield zero instead of an out-of-range read.
    function automatic logic [NIBBLE_W-1:0] nib_get(input logic [WIDTH-1:0] vec,
                                                    input logic [IDX_W-1:0] sel);
        logic [NIBBLE_W-1:0] r;
        r = {NIBBLE_W{1'b0}};
        for (int n = 0; n < NIBBLES; n++) begin
            if (sel == IDX_W'(n)) begin
                r = vec[n*NIBBLE_W +: NIBBLE_W];
            end
        end
        return r;
    endfunction

    // Return 'vec' with nibble 'sel' replaced by 'nib'.
    function automatic logic [WIDTH-1:0] nib_put(input logic [WIDTH-1:0]    vec,
                                                 input logic [IDX_W-1:0]    sel,
                                                 input logic [NIBBLE_W-1:0] nib);
        logic [WIDTH-1:0] r;
        r = vec;
        for (int n = 0; n < NIBBLES; n++) begin
            if (sel == IDX_W'(n)) begin
                r[n*NIBBLE_W +: NIBBLE_W] = nib;
            end
        end
        return r;
    endfunction

    // Slice operands come only from captured registers, never from bus.a/bus.b.
    always_comb begin
        add_a_s = nib_get(a_q, idx_q);
        add_b_s = nib_get(b_q, idx_q);
    end

    fourBitAdder u_slice (
        .a_i    (add_a_s),
        .b_i    (add_b_s),
        .cin_i  (carry_q),
        .sum_o  (add_sum_s),
        .cout_o (add_cout_s)
    );

    // Controller next-state and datapath update.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = bus.cin;
                    idx_d   = {IDX_W{1'b0}};
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                sum_d   = nib_put(sum_q, idx_q, add_sum_s);
                carry_d = add_cout_s;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(NIBBLES - 1)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                // Result is held until consumed; always go back through idle.
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            sum_q   <= {WIDTH{1'b0}};
            carry_q <= 1'b0;
            idx_q   <= {IDX_W{1'b0}};
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
        end
    end

    // Handshake flags are decoded from the state register only.
    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = carry_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Testbench for nibble_serial_adder: directed and random adds on a 4-nibble
// and a 1-nibble instance, checked against plain integer addition.
module tb_nibble_serial_adder;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [15:0] exp_sum4;
    logic        exp_cout4;
    logic [3:0]  exp_sum1;
    logic        exp_cout1;

    nibble_serial_adder_if #(.NIBBLES(4)) bus4 ();
    nibble_serial_adder_if #(.NIBBLES(1)) bus1 ();

    nibble_serial_adder #(.NIBBLES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    nibble_serial_adder #(.NIBBLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit in case the design never answers.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present operands for one cycle on the 4-nibble instance; afterwards the
    // inputs are scrambled to show they are not sampled again.
    task automatic accept4(input logic [15:0] a, input logic [15:0] b, input logic c, input string tag);
        logic [16:0] full;
        full      = 17'(a) + 17'(b) + 17'(c);
        exp_sum4  = full[15:0];
        exp_cout4 = full[16];
        @(negedge clk);
        check({tag, ".in_ready"}, 32'(bus4.in_ready), 32'd1);
        bus4.a = a; bus4.b = b; bus4.cin = c; bus4.in_valid = 1'b1;
        @(negedge clk);
        bus4.in_valid = 1'b0;
        bus4.a = 16'($urandom); bus4.b = 16'($urandom); bus4.cin = 1'($urandom);
    endtask

    // Wait (bounded) for out_valid and check latency and result.
    task automatic wait4(input string tag);
        int lat;
        lat = 0;
        while (bus4.out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), 32'd4);
        check({tag, ".sum"}, 32'(bus4.sum), 32'(exp_sum4));
        check({tag, ".cout"}, 32'(bus4.cout), 32'(exp_cout4));
    endtask

    task automatic release4(input string tag);
        bus4.out_ready = 1'b1;
        @(negedge clk);
        bus4.out_ready = 1'b0;
        check({tag, ".out_valid_drop"}, 32'(bus4.out_valid), 32'd0);
        check({tag, ".in_ready_back"}, 32'(bus4.in_ready), 32'd1);
    endtask

    task automatic add1(input logic [3:0] a, input logic [3:0] b, input logic c, input string tag);
        logic [4:0] full;
        int lat;
        full      = 5'(a) + 5'(b) + 5'(c);
        exp_sum1  = full[3:0];
        exp_cout1 = full[4];
        @(negedge clk);
        check({tag, ".in_ready"}, 32'(bus1.in_ready), 32'd1);
        bus1.a = a; bus1.b = b; bus1.cin = c; bus1.in_valid = 1'b1;
        @(negedge clk);
        bus1.in_valid = 1'b0;
        bus1.a = 4'($urandom); bus1.b = 4'($urandom); bus1.cin = 1'($urandom);
        lat = 0;
        while (bus1.out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), 32'd1);
        check({tag, ".sum"}, 32'(bus1.sum), 32'(exp_sum1));
        check({tag, ".cout"}, 32'(bus1.cout), 32'(exp_cout1));
        bus1.out_ready = 1'b1;
        @(negedge clk);
        bus1.out_ready = 1'b0;
        check({tag, ".in_ready_back"}, 32'(bus1.in_ready), 32'd1);
    endtask

    initial begin
        logic [15:0] held_sum;
        logic        held_cout;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0; bus4.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0; bus1.out_ready = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst.in_ready", 32'(bus4.in_ready), 32'd1);
        check("rst.out_valid", 32'(bus4.out_valid), 32'd0);
        check("rst.sum", 32'(bus4.sum), 32'd0);
        check("rst.cout", 32'(bus4.cout), 32'd0);
        rst_n = 1'b1;

        // Directed adds.
        accept4(16'h1234, 16'h4321, 1'b0, "d1"); wait4("d1"); release4("d1");
        accept4(16'hFFFF, 16'h0001, 1'b0, "d2"); wait4("d2"); release4("d2");
        accept4(16'hFFFF, 16'hFFFF, 1'b1, "d3"); wait4("d3"); release4("d3");
        accept4(16'h0000, 16'h0000, 1'b0, "d4"); wait4("d4"); release4("d4");

        // Backpressure: result held, new operands ignored and not queued.
        accept4(16'($urandom), 16'($urandom), 1'($urandom), "bp");
        wait4("bp");
        held_sum  = exp_sum4;
        held_cout = exp_cout4;
        for (int i = 0; i < 10; i++) begin
            bus4.in_valid = 1'b1;
            bus4.a = 16'($urandom); bus4.b = 16'($urandom); bus4.cin = 1'($urandom);
            @(negedge clk);
            check($sformatf("bp.hold_sum%0d", i), 32'(bus4.sum), 32'(held_sum));
            check($sformatf("bp.hold_cout%0d", i), 32'(bus4.cout), 32'(held_cout));
            check($sformatf("bp.in_ready%0d", i), 32'(bus4.in_ready), 32'd0);
            check($sformatf("bp.out_valid%0d", i), 32'(bus4.out_valid), 32'd1);
        end
        bus4.in_valid = 1'b0;
        release4("bp");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("bp.no_queue%0d", i), 32'(bus4.out_valid), 32'd0);
        end

        // Reset two cycles into a run abandons it.
        accept4(16'($urandom), 16'($urandom), 1'b1, "mr");
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mr.out_valid", 32'(bus4.out_valid), 32'd0);
        check("mr.in_ready", 32'(bus4.in_ready), 32'd1);
        check("mr.sum", 32'(bus4.sum), 32'd0);
        check("mr.cout", 32'(bus4.cout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("mr.no_result%0d", i), 32'(bus4.out_valid), 32'd0);
        end
        accept4(16'h0F0F, 16'h00F1, 1'b0, "mr2"); wait4("mr2"); release4("mr2");

        // Random adds against integer addition.
        for (int i = 0; i < 12; i++) begin
            accept4(16'($urandom), 16'($urandom), 1'($urandom), $sformatf("r%0d", i));
            wait4($sformatf("r%0d", i));
            release4($sformatf("r%0d", i));
        end

        // Single-nibble instance.
        add1(4'h9, 4'h8, 1'b1, "n1d");
        add1(4'hF, 4'h0, 1'b1, "n1c");
        for (int i = 0; i < 6; i++) begin
            add1(4'($urandom), 4'($urandom), 1'($urandom), $sformatf("n1r%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
